pixel_stream_tx: RTL
====================

Name: pixel_stream_tx

Overview:
- Transmit side of the raster pixel stream that the edge-detection pipeline consumes.
- Pops 24-bit RGB pixels from an upstream frame-buffer FIFO (valid/ready) and converts each to 4-bit gray.
- Emits one sample per clock, locked to H_LIMIT x V_LIMIT raster timing including blanking, with a frame-start pulse that the downstream block uses as its new-read strobe.
- Sits between the SDRAM read FIFO and the Canny/toonify filter chain.

Parameters:
- DATA_SIZE, 4: output gray width (MSBs of the 8-bit luma).
- H_LIMIT, 800: total clocks per line, active plus blanking.
- V_LIMIT, 525: total lines per frame.
- H_ACTIVE, 640: active pixels per line, h = 0..H_ACTIVE-1.
- V_ACTIVE, 480: active lines per frame, v = 0..V_ACTIVE-1.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_enable  in  1  request streaming. Sampled in IDLE and at frame end.
- i_clr_err  in  1  clears o_underrun; ignored if an underrun occurs in the same cycle.
- i_pix_valid  in  1  upstream pixel available.
- i_pix_data  in  24  {R[23:16], G[15:8], B[7:0]}.
- o_pix_ready  out  1  pop strobe. A pixel transfers when o_pix_ready && i_pix_valid.
- o_is_new_read  out  1  one-cycle pulse aligned with the o_data sample of (h=0, v=0).
- o_data  out  DATA_SIZE  gray sample. Zero in blanking and on underrun.
- o_h_cursor  out  11  h of the sample currently on o_data.
- o_v_cursor  out  11  v of the sample currently on o_data.
- o_underrun  out  1  sticky: ready asserted while i_pix_valid was low.
- o_busy  out  1  state != S_IDLE.

Behaviour:
- Reset (i_rst high at a clock edge) overrides everything, including mid-frame:
  - state = S_IDLE; internal h_r = v_r = 0.
  - All outputs 0: o_data, o_is_new_read, o_pix_ready, o_h_cursor, o_v_cursor, o_underrun, o_busy.
  - No pixel is popped in the reset cycle.
- States:
  - S_IDLE: o_pix_ready = 0; h_r, v_r held at 0. Go to S_STREAM when i_enable && i_pix_valid.
  - S_STREAM: h_r increments every cycle. At h_r = H_LIMIT-1, h_r wraps to 0 and v_r increments. At (H_LIMIT-1, V_LIMIT-1), v_r wraps to 0. If i_enable is low at that cycle, go to S_IDLE; otherwise start the next frame with no gap.
  - S_STOP: entered from S_STREAM when i_enable falls mid-frame. Same counting as S_STREAM; always returns to S_IDLE at frame end. A re-raised i_enable does not cancel the stop; restart goes through S_IDLE.
- Pop rule: o_pix_ready = (state != S_IDLE) && h_r < H_ACTIVE && v_r < V_ACTIVE. This is combinational from registered state and does not depend on i_pix_valid.
- Underrun: when o_pix_ready && !i_pix_valid:
  - the sample is 0;
  - o_underrun sets on the next cycle;
  - timing does not stall or slip.
- Latency: 1 clock from pop cycle to o_data. The output register stage also carries o_h_cursor, o_v_cursor and o_is_new_read.
- o_is_new_read = 1 exactly in the output cycle of (0,0), including every back-to-back frame.
- Gray conversion:
  - y = 77*R + 150*G + 29*B, unsigned 16-bit; maximum 65280, so no overflow.
  - o_data = y[15:16-DATA_SIZE].
- Blanking (h_r ≥ H_ACTIVE or v_r ≥ V_ACTIVE, or S_IDLE): o_data = 0.
- Transition S_IDLE→S_STREAM: the pixel offered in the transition cycle is not popped. It is popped in the first S_STREAM cycle at (0,0) if still valid.

Decomposition:
- Package toon_pkg:
  - DATA_SIZE;
  - 640x480 and 800x600 timing constants (H_LIMIT, V_LIMIT, H_ACTIVE, V_ACTIVE);
  - enum tx_state_t {S_IDLE, S_STREAM, S_STOP};
  - luma coefficients 77/150/29.
- Sub-module rgb2gray: combinational luma, parameterised on DATA_SIZE. Reusable by other color-space blocks.
- Counters, FSM and output register stay in pixel_stream_tx.

Test Plan:
- Reset, then i_enable=1 with constant-valid FIFO of 0xFFFFFF:
  - first o_is_new_read exactly 2 clocks after i_enable && valid are seen;
  - o_data=0xF for 640 cycles, then 0 for 160;
  - 307200 pops per frame; next o_is_new_read exactly 420000 cycles later.
- Pixels 0xFF0000, 0x00FF00, 0x0000FF, 0x000000 at (0..3, 0) -> o_data 4, 9, 1, 0 with o_h_cursor 0..3.
- i_pix_valid dropped for pixel (5,2):
  - o_data=0 at (5,2); o_underrun=1 from the next cycle; (6,2) still gets the next FIFO word.
  - i_clr_err pulse clears o_underrun.
- i_enable falls at (100,200):
  - streaming continues to (799,524), then o_busy=0 and o_pix_ready=0.
  - Re-enable mid-stop -> no restart until S_IDLE is reached.
- i_rst asserted at (300,100) -> next cycle all outputs 0, S_IDLE, no pop in the reset cycle; re-enable restarts at (0,0) with o_is_new_read.
- i_enable held high across a frame boundary -> (799,524) followed immediately by (0,0) with o_is_new_read=1; no idle cycle.

Source files
------------

// File: rtl/toon_pkg.sv
// Shared types and constants for the toon/edge pixel path: raster timing, gray width, luma weights.
package toon_pkg;

  localparam int DATA_SIZE = 4;

  // 640x480 @ 60 Hz raster (default)
  localparam int H_LIMIT  = 800;
  localparam int V_LIMIT  = 525;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // 800x600 @ 60 Hz raster
  localparam int H_LIMIT_SVGA  = 1056;
  localparam int V_LIMIT_SVGA  = 628;
  localparam int H_ACTIVE_SVGA = 800;
  localparam int V_ACTIVE_SVGA = 600;

  // BT.601 luma weights scaled by 256; they sum to 256 so y never exceeds 16 bits
  localparam int COEF_R = 77;
  localparam int COEF_G = 150;
  localparam int COEF_B = 29;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_STOP   = 2'd2
  } tx_state_t;

endpackage

// File: rtl/rgb2gray.sv
// Combinational RGB888 -> DATA_SIZE-bit gray (MSBs of 8-bit luma); zero latency, no flow control.
module rgb2gray #(
  parameter int DATA_SIZE = toon_pkg::DATA_SIZE
) (
  input  logic [23:0]          i_rgb,
  output logic [DATA_SIZE-1:0] o_gray
);
  import toon_pkg::*;

  logic [15:0] w_y;

  assign w_y = 16'(COEF_R) * {8'd0, i_rgb[23:16]}
             + 16'(COEF_G) * {8'd0, i_rgb[15:8]}
             + 16'(COEF_B) * {8'd0, i_rgb[7:0]};

  assign o_gray = w_y[15 -: DATA_SIZE];

endmodule

// File: rtl/pixel_stream_tx.sv
// Raster-locked gray pixel transmitter: pops RGB from a FIFO, emits one sample/clock, 1-cycle latency.
// Never stalls: an empty FIFO during active video yields a 0 sample and sets sticky o_underrun.
module pixel_stream_tx #(
  parameter int DATA_SIZE = toon_pkg::DATA_SIZE,
  parameter int H_LIMIT   = toon_pkg::H_LIMIT,
  parameter int V_LIMIT   = toon_pkg::V_LIMIT,
  parameter int H_ACTIVE  = toon_pkg::H_ACTIVE,
  parameter int V_ACTIVE  = toon_pkg::V_ACTIVE
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic                 i_clr_err,
  input  logic                 i_pix_valid,
  input  logic [23:0]          i_pix_data,
  output logic                 o_pix_ready,
  output logic                 o_is_new_read,
  output logic [DATA_SIZE-1:0] o_data,
  output logic [10:0]          o_h_cursor,
  output logic [10:0]          o_v_cursor,
  output logic                 o_underrun,
  output logic                 o_busy
);
  import toon_pkg::*;

  localparam logic [10:0] LP_H_LAST = 11'(H_LIMIT - 1);
  localparam logic [10:0] LP_V_LAST = 11'(V_LIMIT - 1);
  localparam logic [10:0] LP_H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] LP_V_ACT  = 11'(V_ACTIVE);

  tx_state_t              r_state, w_state_nxt;
  logic [10:0]            r_h, r_v, w_h_nxt, w_v_nxt;
  logic [10:0]            r_h_cur, r_v_cur;
  logic [DATA_SIZE-1:0]   r_data;
  logic                   r_new, r_underrun;
  logic                   w_h_last, w_v_last, w_frame_end, w_pop;
  logic [DATA_SIZE-1:0]   w_gray;

  rgb2gray #(.DATA_SIZE(DATA_SIZE)) u_rgb2gray (
    .i_rgb  (i_pix_data),
    .o_gray (w_gray)
  );

  assign w_h_last    = (r_h == LP_H_LAST);
  assign w_v_last    = (r_v == LP_V_LAST);
  assign w_frame_end = w_h_last && w_v_last;

  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h;
    w_v_nxt     = r_v;
    // Reset gating keeps a pending reset from consuming a FIFO word
    w_pop       = (r_state != S_IDLE) && (r_h < LP_H_ACT) && (r_v < LP_V_ACT) && !i_rst;

    case (r_state)
      S_IDLE:   if (i_enable && i_pix_valid) w_state_nxt = S_STREAM;
      S_STREAM: begin
        if (w_frame_end) begin
          if (!i_enable) w_state_nxt = S_IDLE;
        end else if (!i_enable) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP:   if (w_frame_end) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase

    if (r_state != S_IDLE) begin
      if (w_h_last) begin
        w_h_nxt = '0;
        w_v_nxt = w_v_last ? 11'd0 : r_v + 11'd1;
      end else begin
        w_h_nxt = r_h + 11'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_h        <= '0;
      r_v        <= '0;
      r_data     <= '0;
      r_h_cur    <= '0;
      r_v_cur    <= '0;
      r_new      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_h     <= w_h_nxt;
      r_v     <= w_v_nxt;
      r_data  <= (w_pop && i_pix_valid) ? w_gray : '0;
      r_h_cur <= r_h;
      r_v_cur <= r_v;
      r_new   <= (r_state != S_IDLE) && (r_h == 11'd0) && (r_v == 11'd0);
      // A fresh underrun wins over a simultaneous clear
      if (w_pop && !i_pix_valid) r_underrun <= 1'b1;
      else if (i_clr_err)        r_underrun <= 1'b0;
    end
  end

  assign o_pix_ready   = w_pop;
  assign o_is_new_read = r_new;
  assign o_data        = r_data;
  assign o_h_cursor    = r_h_cur;
  assign o_v_cursor    = r_v_cur;
  assign o_underrun    = r_underrun;
  assign o_busy        = (r_state != S_IDLE);

endmodule
